// File: rtl/vga_fb_reader.sv
// vga_fb_reader: VGA timing generator and frame-buffer read engine.
//
// Generates 640x480@60 timing (800x525 totals) on the 25 MHz pixel clock,
// issues one registered frame-buffer read address per pixel and drives RGB444
// plus sync aligned to the one-cycle RAM read latency. The stored
// CAM_SCREEN_X x CAM_SCREEN_Y image is upscaled 1x/2x/4x. The scale is
// selected at run time and latched only at the frame boundary.
//
// Ports:
//   clk          pixel clock, rising edge
//   rst          asynchronous active-high reset
//   scale_mode   00=1x, 01=2x, 1x=4x; sampled at (h,v)=(last,last)
//   ram_addr     registered read address (one cycle after the counters)
//   ram_data     read data, valid one cycle after ram_addr
//   VGA_*        sync (active low) and colour, two cycles after the counters
//   posX/posY    undelayed counters h/v
//   frame_start  high while (h,v)=(0,0), outside reset
//
// The H_*/V_* timing parameters default to the standard 640x480 mode.
// Counters are 10 bits wide, so totals must stay at or below 1024.
// The image dimensions must fit in 10 bits.
module vga_fb_reader #(
  parameter int unsigned AW           = 15,
  parameter int unsigned DW           = 12,
  parameter int unsigned CAM_SCREEN_X = 160,
  parameter int unsigned CAM_SCREEN_Y = 120,
  parameter logic [11:0] FILL_COLOR   = 12'h000,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    scale_mode,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_data,
  output logic          VGA_Hsync_n,
  output logic          VGA_Vsync_n,
  output logic [3:0]    VGA_R,
  output logic [3:0]    VGA_G,
  output logic [3:0]    VGA_B,
  output logic [9:0]    posX,
  output logic [9:0]    posY,
  output logic          frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncFirst = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VSyncFirst = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] ImgW       = 10'(CAM_SCREEN_X);
  localparam logic [9:0] ImgH       = 10'(CAM_SCREEN_Y);

  localparam logic [AW-1:0] FillAddr = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);
  localparam logic [AW-1:0] RowStep  = AW'(CAM_SCREEN_X);

  // Stage 0: counters, scale and the row base (y * CAM_SCREEN_X) for the current line.
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [1:0]    s_q, s_d;
  logic [AW-1:0] row_base_q, row_base_d;

  logic [9:0]    x0, y0, v_inc, y_inc, low_mask;
  logic          h_wrap, v_wrap;
  logic          active0, in_img0, hs0_n, vs0_n;
  logic [AW-1:0] addr0;

  // Stage 1 / stage 2 pipeline.
  logic [AW-1:0] ram_addr_q;
  logic          act1_q, img1_q, hs1_n_q, vs1_n_q;
  logic          act2_q, img2_q, hs2_n_q, vs2_n_q;
  logic [11:0]   rgb;

  always_comb begin
    h_wrap = (h_q == HLast);
    v_wrap = (v_q == VLast);
    v_inc  = v_q + 10'd1;

    x0    = h_q >> s_q;
    y0    = v_q >> s_q;
    y_inc = v_inc >> s_q;

    case (s_q)
      2'd0:    low_mask = 10'd0;
      2'd1:    low_mask = 10'd1;
      default: low_mask = 10'd3;
    endcase

    h_d        = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d        = v_q;
    s_d        = s_q;
    row_base_d = row_base_q;

    if (h_wrap) begin
      if (v_wrap) begin
        v_d        = 10'd0;
        row_base_d = '0;
        case (scale_mode)
          2'b00:   s_d = 2'd0;
          2'b01:   s_d = 2'd1;
          default: s_d = 2'd2;
        endcase
      end else begin
        v_d = v_inc;
        // y advances only on lines whose low s bits wrap to zero; once y leaves the
        // image the base is frozen so it never overflows (it is unused there).
        if (((v_inc & low_mask) == 10'd0) && (y_inc < ImgH)) begin
          row_base_d = row_base_q + RowStep;
        end
      end
    end

    active0 = (h_q < HActive) && (v_q < VActive);
    in_img0 = active0 && (x0 < ImgW) && (y0 < ImgH);
    addr0   = in_img0 ? (row_base_q + AW'(x0)) : FillAddr;
    hs0_n   = !((h_q >= HSyncFirst) && (h_q <= HSyncLast));
    vs0_n   = !((v_q >= VSyncFirst) && (v_q <= VSyncLast));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      s_q        <= 2'd2;
      row_base_q <= '0;
      ram_addr_q <= '0;
      act1_q     <= 1'b0;
      img1_q     <= 1'b0;
      hs1_n_q    <= 1'b1;
      vs1_n_q    <= 1'b1;
      act2_q     <= 1'b0;
      img2_q     <= 1'b0;
      hs2_n_q    <= 1'b1;
      vs2_n_q    <= 1'b1;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      s_q        <= s_d;
      row_base_q <= row_base_d;
      ram_addr_q <= addr0;
      act1_q     <= active0;
      img1_q     <= in_img0;
      hs1_n_q    <= hs0_n;
      vs1_n_q    <= vs0_n;
      act2_q     <= act1_q;
      img2_q     <= img1_q;
      hs2_n_q    <= hs1_n_q;
      vs2_n_q    <= vs1_n_q;
    end
  end

  // ram_data arrives in the same cycle as the stage-2 flags, so the colour mux
  // sits after the RAM output register rather than adding another cycle.
  always_comb begin
    rgb = 12'h000;
    if (act2_q) begin
      rgb = img2_q ? ram_data[11:0] : FILL_COLOR;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign VGA_Hsync_n = hs2_n_q;
  assign VGA_Vsync_n = vs2_n_q;
  assign VGA_R       = rgb[11:8];
  assign VGA_G       = rgb[7:4];
  assign VGA_B       = rgb[3:0];
  assign posX        = h_q;
  assign posY        = v_q;
  assign frame_start = !rst && (h_q == 10'd0) && (v_q == 10'd0);

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench for vga_fb_reader with a shortened vertical frame (24 lines)
// and a 100x6 image so that several frames and all three scales fit in a short run.
module tb_vga_fb_reader;

  localparam int unsigned AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    scale_mode = 2'b00;
  logic [AW-1:0] ram_addr;
  logic [11:0]   ram_data = 12'h000;
  logic          VGA_Hsync_n, VGA_Vsync_n, frame_start;
  logic [3:0]    VGA_R, VGA_G, VGA_B;
  logic [9:0]    posX, posY;

  vga_fb_reader #(
    .AW(AW), .DW(12), .CAM_SCREEN_X(100), .CAM_SCREEN_Y(6), .FILL_COLOR(12'h5A3),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) dut (
    .clk(clk), .rst(rst), .scale_mode(scale_mode), .ram_addr(ram_addr),
    .ram_data(ram_data), .VGA_Hsync_n(VGA_Hsync_n), .VGA_Vsync_n(VGA_Vsync_n),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .posX(posX), .posY(posY),
    .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // RAM model: one-cycle read latency, data = low 12 address bits.
  always @(posedge clk) ram_data <= ram_addr[11:0];

  // Cycles since reset release; 0 is the cycle in which h=0 before the first edge.
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef enum int {KPosX, KPosY, KFs, KAddr, KRgb, KHs, KVs} kind_e;
  typedef struct {
    int    key;
    kind_e kind;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   ph     = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic int actual(kind_e k);
    case (k)
      KPosX:   return int'(posX);
      KPosY:   return int'(posY);
      KFs:     return int'(frame_start);
      KAddr:   return int'(ram_addr);
      KRgb:    return int'({VGA_R, VGA_G, VGA_B});
      KHs:     return int'(VGA_Hsync_n);
      default: return int'(VGA_Vsync_n);
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations due at this (phase, cycle).
  always @(negedge clk) begin
    int key;
    key = ph * 100000 + cyc;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].key == key) begin
        checks++;
        if (actual(sb[i].kind) != sb[i].exp) begin
          errors++;
          $display("FAIL %s ph%0d cyc%0d got %0d expected %0d", sb[i].kind.name(), ph, cyc,
                   actual(sb[i].kind), sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].key < key) begin
        checks++;
        errors++;
        $display("FAIL %s key %0d never sampled, expected %0d", sb[i].kind.name(), sb[i].key,
                 sb[i].exp);
        sb.delete(i);
      end
    end
  end

  // Queue an expectation for observation cycle c, issued two cycles ahead.
  task automatic expect_at(input int c, input kind_e k, input int e);
    while (cyc < c - 2) begin
      @(posedge clk);
      #1;
    end
    sb.push_back('{ph * 100000 + c, k, e});
  endtask

  task automatic drive_scale(input int c, input logic [1:0] m);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    scale_mode = m;
  endtask

  task automatic expect_reset_state();
    expect_at(0, KPosX, 0);
    expect_at(0, KPosY, 0);
    expect_at(0, KFs, 0);
    expect_at(0, KAddr, 0);
    expect_at(0, KRgb, 0);
    expect_at(0, KHs, 1);
    expect_at(0, KVs, 1);
  endtask

  initial begin
    #(40 * 60000);
    errors++;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase 0: held in reset.
    expect_reset_state();
    repeat (3) @(posedge clk);
    #1;
    ph  = 1;
    rst = 1'b0;

    // Frame 0: scale 4x from reset; scale_mode=00 is latched for frame 1.
    expect_at(0, KPosX, 0);
    expect_at(0, KPosY, 0);
    expect_at(0, KFs, 1);
    expect_at(0, KAddr, 0);
    expect_at(0, KRgb, 0);
    expect_at(0, KHs, 1);
    expect_at(1, KFs, 0);
    expect_at(1, KRgb, 0);
    expect_at(5, KAddr, 1);          // (4,0)
    expect_at(6, KRgb, 1);
    expect_at(401, KAddr, 600);      // (400,0) right of image
    expect_at(402, KRgb, 'h5A3);
    expect_at(641, KAddr, 600);      // (640,0) h blanking
    expect_at(642, KRgb, 0);
    expect_at(657, KHs, 1);
    expect_at(658, KHs, 0);
    expect_at(753, KHs, 0);
    expect_at(754, KHs, 1);
    expect_at(3201, KAddr, 100);     // (0,4)
    expect_at(3202, KRgb, 100);
    expect_at(12400, KAddr, 399);    // (399,15) last image pixel
    expect_at(12401, KRgb, 399);
    expect_at(12901, KAddr, 600);    // (100,16) v blanking
    expect_at(12902, KRgb, 0);
    expect_at(14401, KVs, 1);
    expect_at(14402, KVs, 0);
    expect_at(16001, KVs, 0);
    expect_at(16002, KVs, 1);
    expect_at(19199, KFs, 0);

    // Frame 1: 1x. Mid-frame switch to 2x must not take effect until frame 2.
    expect_at(19200, KFs, 1);
    expect_at(19200, KPosY, 0);
    expect_at(19301, KAddr, 600);    // (100,0)
    expect_at(19302, KRgb, 'h5A3);
    expect_at(20006, KAddr, 105);    // (5,1)
    expect_at(20007, KRgb, 105);
    drive_scale(22400, 2'b01);
    expect_at(23211, KAddr, 510);    // (10,5)
    expect_at(23212, KRgb, 510);
    expect_at(23300, KAddr, 599);    // (99,5)
    expect_at(24001, KAddr, 600);    // (0,6) below image
    expect_at(24002, KRgb, 'h5A3);
    expect_at(31841, KRgb, 'h5A3);   // (639,15)

    // Frame 2: 2x.
    expect_at(38400, KFs, 1);
    expect_at(38403, KAddr, 1);      // (2,0)
    expect_at(38601, KAddr, 600);    // (200,0)
    expect_at(38602, KRgb, 'h5A3);
    expect_at(40001, KAddr, 100);    // (0,2)
    expect_at(40804, KAddr, 101);    // (3,3)
    expect_at(40805, KRgb, 101);
    expect_at(47400, KAddr, 599);    // (199,11)
    expect_at(48001, KAddr, 600);    // (0,12)

    // Phase 2: async reset at h=300 while RGB shows FILL; checked before any edge.
    while (cyc < 48300) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    ph  = 2;
    expect_reset_state();
    repeat (2) @(posedge clk);
    #1;

    // Phase 3: restart; scale returns to 4x although scale_mode is still 01.
    ph  = 3;
    rst = 1'b0;
    expect_at(0, KPosX, 0);
    expect_at(0, KFs, 1);
    expect_at(0, KAddr, 0);
    expect_at(0, KRgb, 0);
    expect_at(1, KPosX, 1);
    expect_at(1, KRgb, 0);
    expect_at(9, KAddr, 2);          // (8,0)
    expect_at(657, KHs, 1);
    expect_at(658, KHs, 0);
    expect_at(1601, KAddr, 0);       // (0,2)

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s key %0d left unchecked", sb[0].kind.name(), sb[0].key);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
